merge_3: RTL and testbench
==========================

Name: merge_3

Overview:
- Clocked three-way merge for the four-phase req/ack pipeline. It collects results from the three execution branches (1 = branch/jump, 2 = load/store, 3 = ALU/NOP) back into one writeback channel.
- It is the join counterpart of the opcode-steered three-way split.
- Upstream requests and the downstream ack are synchronised into the clock domain.
- One branch is granted at a time by round-robin. Its bundled data is latched and a full four-phase cycle is completed on both sides.

Parameters:
- DATA_W, 32, width of the result bus per branch.
- RD_W, 5, width of the destination register index.
- SYNC_STAGES, 2, flops per synchroniser on req_1..3 and ack_in. Legal values are 2 or 3.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_1, req_2, req_3  in  1 each  upstream four-phase requests.
- data_1, data_2, data_3  in  DATA_W each  bundled results; stable while the matching req_x is high.
- rd_1, rd_2, rd_3  in  RD_W each  bundled destination index.
- we_1, we_2, we_3  in  1 each  bundled writeback enable.
- ack_1, ack_2, ack_3  out  1 each  upstream acknowledges.
- req_out  out  1  downstream request.
- ack_in  in  1  downstream acknowledge.
- data_out  out  DATA_W  latched result.
- rd_out  out  RD_W  latched index.
- we_out  out  1  latched enable.
- src_out  out  2  granted branch: 1, 2 or 3; 0 when idle.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset values: ack_1..3 = 0, req_out = 0, data_out = 0, rd_out = 0, we_out = 0, src_out = 0, busy = 0. State is IDLE, the round-robin pointer is 3, and synchroniser flops are 0.
- Synchronised signals are named rq_s[1..3] and ak_s.

FSM states: IDLE, SEND, ACK.
- IDLE:
  - Waits until ak_s = 0 and at least one rq_s = 1.
  - It then grants the first requester in the order pointer+1, pointer+2, pointer+3 (mod 3, values 1..3).
  - On that edge it latches data/rd/we of the winner into the outputs, sets src_out, sets pointer to the winner, sets req_out = 1 and goes to SEND.
- SEND:
  - Holds req_out = 1.
  - When ak_s = 1: req_out <= 0, ack_<src> <= 1, go to ACK.
- ACK:
  - Holds ack_<src> = 1 and req_out = 0.
  - When rq_s[src] = 0 and ak_s = 0: ack_<src> <= 0, src_out <= 0, go to IDLE.
  - data_out, rd_out and we_out keep their values until the next grant.

Latency:
- req_x rise to req_out rise is SYNC_STAGES+1 rising edges, assuming setup is met and the block is idle with ak_s = 0.
- ak_s = 1 to ack_x rise is 1 edge.

Boundary conditions:
- Simultaneous requests: exactly one is granted. Losers keep ack = 0 and are served in later rounds in round-robin order, so there is no starvation.
- A request arriving during SEND or ACK stays pending and is not sampled until IDLE.
- ack_in already high in IDLE (prior cycle not returned to zero): no grant until it falls.
- Granted req_x falling before ack_x (protocol violation): ignored. SEND completes normally and ACK exits once both are low.
- ack_in falling while in SEND: no effect. The block waits for ak_s = 1.
- Only the granted branch's ack is ever driven high. At most one of ack_1..3 is high at any time.
- Reset mid-operation: all outputs drop asynchronously to their reset values. An upstream req still high after reset is re-granted as a fresh transaction; a duplicate writeback is accepted system behaviour.

Decomposition:
- Package merge_pkg holds:
  - state enum merge_state_t {IDLE, SEND, ACK};
  - src_id_t, a 2-bit type, with constants SRC_NONE = 0, SRC_BJ = 1, SRC_LS = 2, SRC_ALU = 3;
  - default SYNC_STAGES.
- Sub-module sync_ff: a SYNC_STAGES-deep flop chain with async active-low reset to 0. It is instantiated 4 times.
- Round-robin selection is a function in merge_3.

Test Plan:
- Reset release, req_2 = 1, data_2 = 0xDEADBEEF, rd_2 = 7, we_2 = 1 → req_out rises at edge 3 with data_out = 0xDEADBEEF, rd_out = 7, src_out = 2. Then ack_in = 1 → ack_2 = 1 and req_out = 0 one edge after ak_s. Then req_2 = 0 and ack_in = 0 → ack_2 = 0, src_out = 0, busy = 0.
- req_1, req_2 and req_3 raised on the same edge, each completing its handshake and re-raising → grant order is 1, 2, 3, 1, 2, 3 and no branch is served twice in a row while others wait.
- ack_in held high from reset, req_3 = 1 → no grant. Drop ack_in → req_out rises SYNC_STAGES+1 edges later with src_out = 3.
- In SEND, req_1 dropped early → req_out stays high until ack_in. ack_1 pulses, then clears once ack_in falls. No second grant to branch 1.
- In ACK with ack_3 = 1, assert rst_n = 0 asynchronously → all outputs are 0 before the next edge. Release with req_3 still high → a new grant to 3 after SYNC_STAGES+1 edges.
- Random four-phase traffic on all three branches for 10k cycles, checked by assertions:
  - ack one-hot-or-zero;
  - req_out never high in ACK;
  - every upstream request is acknowledged exactly once;
  - the output data sequence matches a scoreboard.

Source files
------------

// File: rtl/merge_pkg.sv
// Shared types and constants for the three-way result merge.
package merge_pkg;

    // Handshake FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2
    } merge_state_t;

    // Branch identifier carried on src_out
    typedef logic [1:0] src_id_t;

    localparam src_id_t SRC_NONE = 2'd0;
    localparam src_id_t SRC_BJ   = 2'd1;
    localparam src_id_t SRC_LS   = 2'd2;
    localparam src_id_t SRC_ALU  = 2'd3;

    // Synchroniser depth used when the instantiating level does not override it
    localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single-bit level crossing into clk.
module sync_ff
    import merge_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Each stage samples the previous one; stage 0 samples the raw input
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign chain_d[gi] = d;
            end else begin : g_rest
                assign chain_d[gi] = chain_q[gi-1];
            end
        end
    endgenerate

    // Shift register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/merge_3.sv
// Round-robin join of three four-phase result channels into one writeback channel.
module merge_3
    import merge_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int RD_W        = 5,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT   // 2 or 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_1,
    input  logic              req_2,
    input  logic              req_3,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic [DATA_W-1:0] data_3,
    input  logic [RD_W-1:0]   rd_1,
    input  logic [RD_W-1:0]   rd_2,
    input  logic [RD_W-1:0]   rd_3,
    input  logic              we_1,
    input  logic              we_2,
    input  logic              we_3,
    output logic              ack_1,
    output logic              ack_2,
    output logic              ack_3,
    output logic              req_out,
    input  logic              ack_in,
    output logic [DATA_W-1:0] data_out,
    output logic [RD_W-1:0]   rd_out,
    output logic              we_out,
    output logic [1:0]        src_out,
    output logic              busy
);

    // Bit 0 is branch 1, bit 2 is branch 3
    logic [2:0] req_raw;
    logic [2:0] rq_s;
    logic       ak_s;

    assign req_raw = {req_3, req_2, req_1};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_req_sync
            sync_ff #(.STAGES(SYNC_STAGES)) u_sync_req (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (req_raw[gi]),
                .q     (rq_s[gi])
            );
        end
    endgenerate

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ack (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ack_in),
        .q     (ak_s)
    );

    // Searches pointer+1, pointer+2, pointer+3 (wrapping 3 -> 1); NONE if no request
    function automatic src_id_t rr_pick(input src_id_t ptr, input logic [2:0] rq);
        src_id_t cand;
        src_id_t win;
        win  = SRC_NONE;
        cand = ptr;
        for (int k = 0; k < 3; k++) begin
            cand = (cand == SRC_ALU || cand == SRC_NONE) ? SRC_BJ : src_id_t'(cand + 2'd1);
            if (win == SRC_NONE && rq[cand - 2'd1]) begin
                win = cand;
            end
        end
        return win;
    endfunction

    // One-hot ack pattern for a branch id
    function automatic logic [2:0] src_onehot(input src_id_t src);
        logic [2:0] oh;
        case (src)
            SRC_BJ:  oh = 3'b001;
            SRC_LS:  oh = 3'b010;
            SRC_ALU: oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    merge_state_t      state_q, state_d;
    src_id_t           ptr_q, ptr_d;
    src_id_t           src_q, src_d;
    logic [2:0]        ack_q, ack_d;
    logic              req_out_q, req_out_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    src_id_t           win;

    // Next-state and registered-output logic of the handshake FSM
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        src_d     = src_q;
        ack_d     = ack_q;
        req_out_d = req_out_q;
        data_d    = data_q;
        rd_d      = rd_q;
        we_d      = we_q;
        win       = rr_pick(ptr_q, rq_s);

        case (state_q)
            IDLE: begin
                // A downstream ack still high from the previous cycle blocks any grant
                if (!ak_s && rq_s != 3'b000) begin
                    src_d     = win;
                    ptr_d     = win;
                    req_out_d = 1'b1;
                    state_d   = SEND;
                    case (win)
                        SRC_BJ: begin
                            data_d = data_1;
                            rd_d   = rd_1;
                            we_d   = we_1;
                        end
                        SRC_LS: begin
                            data_d = data_2;
                            rd_d   = rd_2;
                            we_d   = we_2;
                        end
                        default: begin
                            data_d = data_3;
                            rd_d   = rd_3;
                            we_d   = we_3;
                        end
                    endcase
                end
            end
            SEND: begin
                if (ak_s) begin
                    req_out_d = 1'b0;
                    ack_d     = src_onehot(src_q);
                    state_d   = ACK;
                end
            end
            ACK: begin
                // An early-dropped upstream req simply satisfies this condition sooner
                if ((rq_s & src_onehot(src_q)) == 3'b000 && !ak_s) begin
                    ack_d   = 3'b000;
                    src_d   = SRC_NONE;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d     = 3'b000;
                req_out_d = 1'b0;
                src_d     = SRC_NONE;
                state_d   = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= SRC_ALU;
            src_q     <= SRC_NONE;
            ack_q     <= 3'b000;
            req_out_q <= 1'b0;
            data_q    <= '0;
            rd_q      <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            src_q     <= src_d;
            ack_q     <= ack_d;
            req_out_q <= req_out_d;
            data_q    <= data_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
        end
    end

    assign ack_1    = ack_q[0];
    assign ack_2    = ack_q[1];
    assign ack_3    = ack_q[2];
    assign req_out  = req_out_q;
    assign data_out = data_q;
    assign rd_out   = rd_q;
    assign we_out   = we_q;
    assign src_out  = src_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_merge_3.sv
// Directed and randomised checks of the three-way four-phase merge.
module tb_merge_3;

    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int SYNC   = 2;
    localparam int N_RND  = 150;

    logic              clk;
    logic              rst_n;
    logic [3:1]        req_v;
    logic [DATA_W-1:0] data_v [1:3];
    logic [RD_W-1:0]   rd_v   [1:3];
    logic [3:1]        we_v;
    logic              ack_in;
    logic              ack_1, ack_2, ack_3;
    logic              req_out;
    logic [DATA_W-1:0] data_out;
    logic [RD_W-1:0]   rd_out;
    logic              we_out;
    logic [1:0]        src_out;
    logic              busy;
    logic [3:1]        ack_v;

    assign ack_v = {ack_3, ack_2, ack_1};

    merge_3 #(.DATA_W(DATA_W), .RD_W(RD_W), .SYNC_STAGES(SYNC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_1    (req_v[1]),
        .req_2    (req_v[2]),
        .req_3    (req_v[3]),
        .data_1   (data_v[1]),
        .data_2   (data_v[2]),
        .data_3   (data_v[3]),
        .rd_1     (rd_v[1]),
        .rd_2     (rd_v[2]),
        .rd_3     (rd_v[3]),
        .we_1     (we_v[1]),
        .we_2     (we_v[2]),
        .we_3     (we_v[3]),
        .ack_1    (ack_1),
        .ack_2    (ack_2),
        .ack_3    (ack_3),
        .req_out  (req_out),
        .ack_in   (ack_in),
        .data_out (data_out),
        .rd_out   (rd_out),
        .we_out   (we_out),
        .src_out  (src_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input logic val, input int budget, input string tag);
        int i = 0;
        while (req_out !== val && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, req_out, val);
    endtask

    task automatic wait_ack(input int b, input logic val, input int budget, input string tag);
        int i = 0;
        while (ack_v[b] !== val && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, ack_v[b], val);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_acks"}, ack_v, 0);
        chk({tag, "_req_out"}, req_out, 0);
        chk({tag, "_data"}, data_out, 0);
        chk({tag, "_rd"}, rd_out, 0);
        chk({tag, "_we"}, we_out, 0);
        chk({tag, "_src"}, src_out, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // Randomised phase bookkeeping
    logic       rand_on = 1'b0;
    int         agents_done = 0;
    int         n_req [1:3];
    int         n_ack [1:3];
    logic [3:1] prev_ack_q;
    logic [37:0] exp_q1 [$];
    logic [37:0] exp_q2 [$];
    logic [37:0] exp_q3 [$];

    // Per-cycle protocol invariants during random traffic
    always @(negedge clk) begin
        prev_ack_q <= ack_v;
        if (rand_on) begin
            chk("ack_onehot", ($countones(ack_v) <= 1), 1);
            if (ack_v != 3'b000) begin
                chk("req_out_in_ack", req_out, 0);
                chk("ack_matches_src", ack_v, 3'b001 << (src_out - 2'd1));
            end
            for (int b = 1; b <= 3; b++) begin
                if (ack_v[b] && !prev_ack_q[b]) n_ack[b] <= n_ack[b] + 1;
            end
        end
    end

    task automatic agent(input int b, input int n);
        logic [DATA_W-1:0] d;
        logic [RD_W-1:0]   r;
        logic              w;
        int                i;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            d = $urandom;
            r = RD_W'($urandom_range(0, 31));
            w = 1'($urandom_range(0, 1));
            data_v[b] = d;
            rd_v[b]   = r;
            we_v[b]   = w;
            case (b)
                1:       exp_q1.push_back({w, r, d});
                2:       exp_q2.push_back({w, r, d});
                default: exp_q3.push_back({w, r, d});
            endcase
            n_req[b]++;
            req_v[b] = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                // Drop the request early once it has been granted
                i = 0;
                while (src_out != 2'(b) && ack_v[b] == 1'b0 && i < 400) begin
                    @(negedge clk);
                    i++;
                end
                req_v[b] = 1'b0;
            end
            wait_ack(b, 1'b1, 400, "rnd_ack_rise");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            req_v[b] = 1'b0;
            wait_ack(b, 1'b0, 400, "rnd_ack_fall");
        end
        agents_done++;
    endtask

    task automatic downstream();
        int          guard = 0;
        logic [37:0] exp;
        while ((agents_done < 3 || req_out) && guard < 30000) begin
            @(negedge clk);
            guard++;
            if (req_out && !ack_in) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                exp = '0;
                case (src_out)
                    2'd1: if (exp_q1.size() > 0) exp = exp_q1.pop_front();
                    2'd2: if (exp_q2.size() > 0) exp = exp_q2.pop_front();
                    2'd3: if (exp_q3.size() > 0) exp = exp_q3.pop_front();
                    default: chk("rnd_src_valid", src_out, 1);
                endcase
                chk("rnd_payload", {we_out, rd_out, data_out}, exp);
                ack_in = 1'b1;
                wait_req(1'b0, 20, "rnd_req_out_fall");
                repeat ($urandom_range(0, 3)) @(negedge clk);
                ack_in = 1'b0;
            end
        end
        chk("rnd_no_timeout", (guard < 30000), 1);
    endtask

    initial begin
        int b;
        rst_n  = 1'b0;
        req_v  = '0;
        we_v   = '0;
        ack_in = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            data_v[i] = '0;
            rd_v[i]   = '0;
            n_req[i]  = 0;
            n_ack[i]  = 0;
        end

        // Reset state, then a single transaction on branch 2
        tick(3);
        chk_all_zero("reset");
        rst_n     = 1'b1;
        req_v[2]  = 1'b1;
        data_v[2] = 32'hDEADBEEF;
        rd_v[2]   = 5'd7;
        we_v[2]   = 1'b1;
        tick(SYNC);
        chk("t1_req_out_early", req_out, 0);
        tick(1);
        chk("t1_req_out_rise", req_out, 1);
        chk("t1_data", data_out, 32'hDEADBEEF);
        chk("t1_rd", rd_out, 7);
        chk("t1_we", we_out, 1);
        chk("t1_src", src_out, 2);
        chk("t1_busy", busy, 1);
        ack_in = 1'b1;
        tick(SYNC);
        chk("t1_ack2_before", ack_2, 0);
        tick(1);
        chk("t1_ack2_rise", ack_2, 1);
        chk("t1_req_out_fall", req_out, 0);
        req_v[2] = 1'b0;
        ack_in   = 1'b0;
        tick(SYNC + 1);
        chk("t1_ack2_fall", ack_2, 0);
        chk("t1_src_idle", src_out, 0);
        chk("t1_busy_idle", busy, 0);
        chk("t1_data_held", data_out, 32'hDEADBEEF);

        // Three simultaneous requesters, each re-raising once: order 1,2,3,1,2,3
        reset_dut();
        for (int i = 1; i <= 3; i++) begin
            data_v[i] = 32'hA000_0000 + 32'(i);
            rd_v[i]   = 5'(i);
            we_v[i]   = 1'b1;
        end
        req_v = 3'b111;
        for (int r = 0; r < 6; r++) begin
            b = (r % 3) + 1;
            wait_req(1'b1, 20, "t2_req_out");
            chk("t2_src", src_out, b);
            chk("t2_data", data_out, 32'hA000_0000 + 32'(b) + 32'h100 * 32'(r / 3));
            ack_in = 1'b1;
            wait_ack(b, 1'b1, 10, "t2_ack_rise");
            chk("t2_acks_onehot", ack_v, 3'b001 << (b - 1));
            req_v[b] = 1'b0;
            ack_in   = 1'b0;
            wait_ack(b, 1'b0, 10, "t2_ack_fall");
            if (r < 3) begin
                data_v[b] = 32'hA000_0100 + 32'(b);
                req_v[b]  = 1'b1;
            end
        end

        // Downstream ack stuck high from reset blocks the grant
        ack_in = 1'b1;
        reset_dut();
        data_v[3] = 32'h3333_0003;
        req_v[3]  = 1'b1;
        tick(6);
        chk("t3_blocked_req_out", req_out, 0);
        chk("t3_blocked_busy", busy, 0);
        ack_in = 1'b0;
        tick(SYNC);
        chk("t3_req_out_early", req_out, 0);
        tick(1);
        chk("t3_req_out_rise", req_out, 1);
        chk("t3_src", src_out, 3);
        ack_in = 1'b1;
        wait_ack(3, 1'b1, 10, "t3_ack_rise");
        req_v[3] = 1'b0;
        ack_in   = 1'b0;
        wait_ack(3, 1'b0, 10, "t3_ack_fall");

        // Granted branch 1 drops its request during SEND
        reset_dut();
        data_v[1] = 32'h1111_0001;
        req_v[1]  = 1'b1;
        wait_req(1'b1, 10, "t4_req_out_rise");
        chk("t4_src", src_out, 1);
        req_v[1] = 1'b0;
        tick(5);
        chk("t4_req_out_held", req_out, 1);
        chk("t4_ack1_low", ack_1, 0);
        ack_in = 1'b1;
        wait_ack(1, 1'b1, 10, "t4_ack_rise");
        chk("t4_req_out_fall", req_out, 0);
        tick(4);
        chk("t4_ack1_held", ack_1, 1);
        ack_in = 1'b0;
        wait_ack(1, 1'b0, 10, "t4_ack_fall");
        tick(6);
        chk("t4_no_regrant", req_out, 0);
        chk("t4_idle", busy, 0);

        // Asynchronous reset in ACK, then re-grant of the still-high request
        reset_dut();
        data_v[3] = 32'h5555_0005;
        rd_v[3]   = 5'd9;
        req_v[3]  = 1'b1;
        wait_req(1'b1, 10, "t5_req_out_rise");
        ack_in = 1'b1;
        wait_ack(3, 1'b1, 10, "t5_ack_rise");
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("t5_async");
        ack_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(SYNC);
        chk("t5_req_out_early", req_out, 0);
        tick(1);
        chk("t5_regrant", req_out, 1);
        chk("t5_regrant_src", src_out, 3);
        ack_in = 1'b1;
        wait_ack(3, 1'b1, 10, "t5_ack2_rise");
        req_v[3] = 1'b0;
        ack_in   = 1'b0;
        wait_ack(3, 1'b0, 10, "t5_ack2_fall");

        // Random four-phase traffic on all branches against a scoreboard
        reset_dut();
        @(negedge clk);
        rand_on = 1'b1;
        fork
            agent(1, N_RND);
            agent(2, N_RND);
            agent(3, N_RND);
            downstream();
        join
        tick(2);
        rand_on = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk("rnd_ack_count", n_ack[i], n_req[i]);
        end
        chk("rnd_queues_empty", exp_q1.size() + exp_q2.size() + exp_q3.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
